// File: rtl/gcn_pkg.sv
// Shared types and defaults for the GCN transformation-pass scheduler.
package gcn_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_W     = 3'd1,
        RD_F     = 3'd2,
        WAIT_MAC = 3'd3,
        DONE     = 3'd4
    } sched_state_e;

    localparam int unsigned WEIGHT_BASE_DEF  = 0;
    localparam int unsigned FEATURE_BASE_DEF = 512;
    localparam int unsigned FEATURE_ROWS_DEF = 6;
    localparam int unsigned WEIGHT_COLS_DEF  = 3;

    // Index width for n slots; a single slot still needs one bit of port.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned W_IDX_W_DEF = idx_w(WEIGHT_COLS_DEF);
    localparam int unsigned F_IDX_W_DEF = idx_w(FEATURE_ROWS_DEF);

endpackage

// File: rtl/gcn_idx_counter.sv
// Modulo index counter with synchronous clear, increment and terminal-count flag.
module gcn_idx_counter #(
    parameter int unsigned MODULO = 2,
    parameter int unsigned WIDTH  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic [WIDTH-1:0] cnt_next_c,
    output logic             tc_c
);

    logic [WIDTH-1:0] cnt_q;

    assign tc_c  = (cnt_q == WIDTH'(MODULO - 1));
    assign cnt_o = cnt_q;

    // Wraps at the terminal count so the index never leaves 0..MODULO-1.
    always_comb begin
        cnt_next_c = cnt_q;
        if (clr_i) begin
            cnt_next_c = '0;
        end else if (inc_i) begin
            cnt_next_c = tc_c ? '0 : cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_next_c;
        end
    end

endmodule

// File: rtl/gcn_sched_ctrl.sv
// Read scheduler for one GCN transformation pass: weight columns, then feature rows paced by the MAC.
// Optional busy-cycle counter output enabled by defining GCN_SCHED_PERF_EN.
module gcn_sched_ctrl
    import gcn_pkg::*;
#(
    parameter int unsigned FEATURE_ROWS  = FEATURE_ROWS_DEF,
    parameter int unsigned WEIGHT_COLS   = WEIGHT_COLS_DEF,
    parameter int unsigned ADDRESS_WIDTH = 13,
    parameter int unsigned WEIGHT_BASE   = WEIGHT_BASE_DEF,
    parameter int unsigned FEATURE_BASE  = FEATURE_BASE_DEF
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic                            mac_done,
    output logic                            enable_read,
    output logic [ADDRESS_WIDTH-1:0]        read_address,
    output logic                            weight_we,
    output logic [idx_w(WEIGHT_COLS)-1:0]   weight_idx,
    output logic                            feat_valid,
    output logic [idx_w(FEATURE_ROWS)-1:0]  feat_idx,
    output logic                            busy,
    output logic                            done
`ifdef GCN_SCHED_PERF_EN
    ,
    output logic [15:0]                     busy_cycles
`endif
);

    localparam int unsigned W_IDX_W = idx_w(WEIGHT_COLS);
    localparam int unsigned F_IDX_W = idx_w(FEATURE_ROWS);

    sched_state_e             state_q, state_d;
    logic [W_IDX_W-1:0]       w_cnt_q, w_cnt_d;
    logic [F_IDX_W-1:0]       f_cnt_q, f_cnt_d;
    logic                     w_tc, f_tc;
    logic                     w_clr, w_inc, f_clr, f_inc;

    logic                     enable_read_q, enable_read_d;
    logic [ADDRESS_WIDTH-1:0] read_address_q, read_address_d;
    logic                     weight_we_q, weight_we_d;
    logic [W_IDX_W-1:0]       weight_idx_q, weight_idx_d;
    logic                     feat_valid_q, feat_valid_d;
    logic [F_IDX_W-1:0]       feat_idx_q, feat_idx_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    gcn_idx_counter #(.MODULO(WEIGHT_COLS), .WIDTH(W_IDX_W)) u_w_cnt (
        .clk        (clk),
        .reset      (reset),
        .clr_i      (w_clr),
        .inc_i      (w_inc),
        .cnt_o      (w_cnt_q),
        .cnt_next_c (w_cnt_d),
        .tc_c       (w_tc)
    );

    gcn_idx_counter #(.MODULO(FEATURE_ROWS), .WIDTH(F_IDX_W)) u_f_cnt (
        .clk        (clk),
        .reset      (reset),
        .clr_i      (f_clr),
        .inc_i      (f_inc),
        .cnt_o      (f_cnt_q),
        .cnt_next_c (f_cnt_d),
        .tc_c       (f_tc)
    );

    // Next state and counter control; outputs are then decoded from the next state so they land registered.
    always_comb begin
        state_d = state_q;
        w_clr   = 1'b0;
        w_inc   = 1'b0;
        f_clr   = 1'b0;
        f_inc   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RD_W;
                    w_clr   = 1'b1;
                    f_clr   = 1'b1;
                end
            end
            RD_W: begin
                w_inc = 1'b1;
                if (w_tc) state_d = RD_F;
            end
            RD_F: state_d = WAIT_MAC;
            WAIT_MAC: begin
                if (mac_done) begin
                    if (f_tc) begin
                        state_d = DONE;
                    end else begin
                        f_inc   = 1'b1;
                        state_d = RD_F;
                    end
                end
            end
            DONE: begin
                if (!start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        enable_read_d  = (state_d == RD_W) || (state_d == RD_F);
        read_address_d = read_address_q;
        if (state_d == RD_W) begin
            read_address_d = ADDRESS_WIDTH'(WEIGHT_BASE + 32'(w_cnt_d));
        end else if (state_d == RD_F) begin
            read_address_d = ADDRESS_WIDTH'(FEATURE_BASE + 32'(f_cnt_d));
        end

        // Memory returns data one cycle after the read, tagged with the index that was read.
        weight_we_d  = (state_q == RD_W);
        weight_idx_d = weight_we_d ? w_cnt_q : weight_idx_q;
        feat_valid_d = (state_q == RD_F);
        feat_idx_d   = feat_valid_d ? f_cnt_q : feat_idx_q;

        busy_d = (state_d == RD_W) || (state_d == RD_F) || (state_d == WAIT_MAC);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            enable_read_q  <= 1'b0;
            read_address_q <= '0;
            weight_we_q    <= 1'b0;
            weight_idx_q   <= '0;
            feat_valid_q   <= 1'b0;
            feat_idx_q     <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            enable_read_q  <= enable_read_d;
            read_address_q <= read_address_d;
            weight_we_q    <= weight_we_d;
            weight_idx_q   <= weight_idx_d;
            feat_valid_q   <= feat_valid_d;
            feat_idx_q     <= feat_idx_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign enable_read  = enable_read_q;
    assign read_address = read_address_q;
    assign weight_we    = weight_we_q;
    assign weight_idx   = weight_idx_q;
    assign feat_valid   = feat_valid_q;
    assign feat_idx     = feat_idx_q;
    assign busy         = busy_q;
    assign done         = done_q;

`ifdef GCN_SCHED_PERF_EN
    logic [15:0] busy_cycles_q, busy_cycles_d;

    // Counts cycles spent busy in the current pass, saturating.
    always_comb begin
        busy_cycles_d = busy_cycles_q;
        if ((state_q == IDLE) && start) begin
            busy_cycles_d = '0;
        end else if (busy_q && (busy_cycles_q != 16'hFFFF)) begin
            busy_cycles_d = busy_cycles_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_cycles_q <= '0;
        end else begin
            busy_cycles_q <= busy_cycles_d;
        end
    end

    assign busy_cycles = busy_cycles_q;
`endif

endmodule

// File: tb/tb_gcn_sched_ctrl.sv
// Self-checking bench for gcn_sched_ctrl: directed scenarios plus a randomized run against a pass-level model.
module tb_gcn_sched_ctrl;

    localparam int FR = 6;
    localparam int WC = 3;
    localparam int WB = 0;
    localparam int FB = 512;
    localparam int LOGN = 4096;

    localparam int S_IDLE = 0;
    localparam int S_W    = 1;
    localparam int S_F    = 2;
    localparam int S_WAIT = 3;
    localparam int S_DONE = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        mac_done = 1'b0;
    logic        enable_read;
    logic [12:0] read_address;
    logic        weight_we;
    logic [gcn_pkg::W_IDX_W_DEF-1:0] weight_idx;
    logic        feat_valid;
    logic [gcn_pkg::F_IDX_W_DEF-1:0] feat_idx;
    logic        busy;
    logic        done;
`ifdef GCN_SCHED_PERF_EN
    logic [15:0] busy_cycles;
`endif

    gcn_sched_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .mac_done     (mac_done),
        .enable_read  (enable_read),
        .read_address (read_address),
        .weight_we    (weight_we),
        .weight_idx   (weight_idx),
        .feat_valid   (feat_valid),
        .feat_idx     (feat_idx),
        .busy         (busy),
        .done         (done)
`ifdef GCN_SCHED_PERF_EN
        ,
        .busy_cycles  (busy_cycles)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int mode  = 1;      // mac_done driver: 0 random, 1 second WAIT cycle, 2 held high
    bit fv_seen = 1'b0;

    // Pass-level model: where the pass is, and what the outputs must read in the current cycle.
    int m_st = S_IDLE, m_w = 0, m_f = 0;
    bit e_rd = 0, e_we = 0, e_fv = 0, e_busy = 0, e_done = 0;
    int e_addr = 0, e_widx = 0, e_fidx = 0, e_bc = 0;

    int addr_log[LOGN];
    int mlog[LOGN];
    int wlog[LOGN];
    int flog[LOGN];
    int n_addr = 0, n_m = 0, n_w = 0, n_f = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        case (mode)
            0:       mac_done = ($urandom_range(0, 2) == 0);
            1:       mac_done = fv_seen;
            2:       mac_done = 1'b1;
            default: mac_done = 1'b0;
        endcase
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_st = S_IDLE; m_w = 0; m_f = 0;
            e_rd = 0; e_addr = 0; e_we = 0; e_widx = 0; e_fv = 0; e_fidx = 0;
            e_busy = 0; e_done = 0; e_bc = 0;
        end else begin
            // Data for last cycle's read arrives now.
            e_we = (m_st == S_W);
            if (e_we) e_widx = m_w;
            e_fv = (m_st == S_F);
            if (e_fv) e_fidx = m_f;
            if (m_st == S_IDLE && start) e_bc = 0;
            else if (m_st == S_W || m_st == S_F || m_st == S_WAIT) e_bc = (e_bc < 65535) ? e_bc + 1 : e_bc;
            case (m_st)
                S_IDLE: if (start) begin m_st = S_W; m_w = 0; m_f = 0; end
                S_W:    if (m_w == WC - 1) m_st = S_F; else m_w++;
                S_F:    m_st = S_WAIT;
                S_WAIT: if (mac_done) begin
                            if (m_f == FR - 1) m_st = S_DONE;
                            else begin m_f++; m_st = S_F; end
                        end
                default: if (!start) m_st = S_IDLE;
            endcase
            e_rd = (m_st == S_W) || (m_st == S_F);
            if (m_st == S_W) e_addr = WB + m_w;
            else if (m_st == S_F) e_addr = FB + m_f;
            e_busy = (m_st == S_W) || (m_st == S_F) || (m_st == S_WAIT);
            e_done = (m_st == S_DONE);
        end
    end

    // Single compare point, mid-cycle.
    always @(negedge clk) begin
        check("enable_read",  32'(enable_read),  32'(e_rd));
        check("read_address", 32'(read_address), 32'(e_addr));
        check("weight_we",    32'(weight_we),    32'(e_we));
        check("weight_idx",   32'(weight_idx),   32'(e_widx));
        check("feat_valid",   32'(feat_valid),   32'(e_fv));
        check("feat_idx",     32'(feat_idx),     32'(e_fidx));
        check("busy",         32'(busy),         32'(e_busy));
        check("done",         32'(done),         32'(e_done));
`ifdef GCN_SCHED_PERF_EN
        check("busy_cycles",  32'(busy_cycles),  32'(e_bc));
`endif
        if (enable_read === 1'b1 && n_addr < LOGN) begin addr_log[n_addr] = 32'(read_address); n_addr++; end
        if (e_rd && n_m < LOGN) begin mlog[n_m] = e_addr; n_m++; end
        if (weight_we === 1'b1 && n_w < LOGN) begin wlog[n_w] = 32'(weight_idx); n_w++; end
        if (feat_valid === 1'b1 && n_f < LOGN) begin flog[n_f] = 32'(feat_idx); n_f++; end
        fv_seen = (feat_valid === 1'b1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int maxc, output int t);
        t = -1;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                t = cyc;
                break;
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_enable_read"},  32'(enable_read),  0);
        check({tag, "_read_address"}, 32'(read_address), 0);
        check({tag, "_weight_we"},    32'(weight_we),    0);
        check({tag, "_weight_idx"},   32'(weight_idx),   0);
        check({tag, "_feat_valid"},   32'(feat_valid),   0);
        check({tag, "_feat_idx"},     32'(feat_idx),     0);
        check({tag, "_busy"},         32'(busy),         0);
        check({tag, "_done"},         32'(done),         0);
`ifdef GCN_SCHED_PERF_EN
        check({tag, "_busy_cycles"},  32'(busy_cycles),  0);
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t, a0, m0, w0, f0, n0;
        int exp_addr[9];
        bit found;
        exp_addr = '{0, 1, 2, 512, 513, 514, 515, 516, 517};

        reset = 1'b1;
        start = 1'b0;
        mode  = 1;
        repeat (3) tick();
        check_all_zero("rst");
        reset = 1'b0;
        repeat (2) tick();

        // Pass with mac_done in the second WAIT_MAC cycle.
        a0 = n_addr; m0 = n_m; w0 = n_w; f0 = n_f;
        start = 1'b1;
        tick();
        t0 = cyc;
        start = 1'b0;
        wait_done(80, t);
        check("s1_done_seen", 32'(t >= 0), 1);
        check("s1_done_latency", 32'(t - t0), 21);
`ifdef GCN_SCHED_PERF_EN
        check("s1_busy_cycles", 32'(busy_cycles), 21);
`endif
        check("s1_read_count", 32'(n_addr - a0), 9);
        for (int i = 0; i < 9; i++) begin
            check($sformatf("s1_addr%0d", i), 32'(addr_log[a0 + i]), 32'(exp_addr[i]));
            check($sformatf("s1_model_addr%0d", i), 32'(mlog[m0 + i]), 32'(exp_addr[i]));
        end
        check("s1_we_count", 32'(n_w - w0), 3);
        for (int i = 0; i < 3; i++) check($sformatf("s1_widx%0d", i), 32'(wlog[w0 + i]), 32'(i));
        check("s1_fv_count", 32'(n_f - f0), 6);
        for (int i = 0; i < 6; i++) check($sformatf("s1_fidx%0d", i), 32'(flog[f0 + i]), 32'(i));
        repeat (2) tick();

        // mac_done held high: two cycles per row.
        mode  = 2;
        start = 1'b1;
        tick();
        t0 = cyc;
        start = 1'b0;
        wait_done(80, t);
        check("s41_done_latency", 32'(t - t0), 15);
        repeat (2) tick();

        // start held through DONE, then released, then a fresh pass.
        start = 1'b1;
        tick();
        wait_done(80, t);
        n0 = n_addr;
        repeat (6) tick();
        check("s42_done_held", 32'(done), 1);
        check("s42_no_new_reads", 32'(n_addr - n0), 0);
        start = 1'b0;
        tick();
        check("s42_done_drop", 32'(done), 0);
        a0 = n_addr;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        check("s42_restart_n", 32'(n_addr - a0), 3);
        for (int i = 0; i < 3; i++) check($sformatf("s42_restart_addr%0d", i), 32'(addr_log[a0 + i]), 32'(i));
        wait_done(80, t);
        repeat (2) tick();

        // Asynchronous reset while waiting on row 3.
        mode  = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            @(negedge clk);
            if (feat_valid === 1'b1 && feat_idx == 3'd3) found = 1'b1;
        end
        check("s43_reached_row3", 32'(found), 1);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_all_zero("s43_async");
        tick();
        tick();
        reset = 1'b0;
        n0 = n_addr;
        repeat (10) tick();
        check("s43_no_read_after_release", 32'(n_addr - n0), 0);
        check("s43_idle_busy", 32'(busy), 0);

        // Randomized traffic with stray start/mac_done and occasional resets.
        mode = 0;
        for (int i = 0; i < 2500; i++) begin
            start = ($urandom_range(0, 7) == 0);
            reset = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 1'b0;
        start = 1'b0;
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
